// File: rtl/led_pkg.sv
// Shared LED-bank definitions: widths, scheduler states and the
// round-robin source picker used by the LED and display schedulers.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SHOW  = 2'd1,
    XFADE = 2'd2
  } sched_state_t;

  // First set mask bit after cur, wrapping; returns cur if no other is set.
  function automatic logic [2:0] next_enabled(
    input logic [2:0] cur,
    input logic [7:0] mask
  );
    logic [2:0] idx;
    logic [2:0] res;
    res = cur;
    for (int k = 7; k >= 1; k--) begin
      idx = cur + 3'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter for a raw button or
// switch; emits the debounced level and a one-cycle rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  logic                  s1_q;
  logic                  s2_q;
  logic [DEBOUNCE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      rise_pulse <= 1'b0;
      if (s2_q == level) begin
        cnt_q <= '0;
      end else if (&cnt_q) begin
        level      <= s2_q;
        rise_pulse <= s2_q;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_source_scheduler.sv
// Round-robin scheduler of pattern sources onto the LED bank with
// dwell/button advance and a carry-out PWM crossfade between sources.
module led_source_scheduler
  import led_pkg::*;
#(
  parameter  int NUM_SRC       = 4,
  parameter  int DWELL_W       = 27,
  parameter  int FADE_BITS     = 8,
  parameter  int FADE_PRESCALE = 16,
  parameter  int DEBOUNCE_W    = 16,
  localparam int SEL_W         = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*LED_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_enable,
  input  logic                     auto_mode,
  input  logic                     advance_btn,
  output logic [LED_W-1:0]         leds,
  output logic [SEL_W-1:0]         active_src,
  output logic                     fading
);

  sched_state_t         state_q, state_d;
  logic [SEL_W-1:0]     cur_q, cur_d;
  logic [SEL_W-1:0]     nxt_q, nxt_d;
  logic [SEL_W-1:0]     cand;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [FADE_BITS-1:0] ramp_q, ramp_d;
  logic [FADE_BITS:0]   acc_q, acc_d;
  logic [LED_W-1:0]     leds_q, leds_d;
  logic [7:0]           mask8;
  logic                 tick;
  logic                 btn_level;
  logic                 btn_rise;
  logic                 trig;
  logic [LED_W-1:0]     src [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src[i] = src_data[i*LED_W +: LED_W];
  end

  button_debouncer #(
    .DEBOUNCE_W (DEBOUNCE_W)
  ) u_btn (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (advance_btn),
    .level      (btn_level),
    .rise_pulse (btn_rise)
  );

  // Ramp step strobe; the prescaler only runs while fading.
  if (FADE_PRESCALE == 0) begin : g_nopre
    assign tick = 1'b1;
  end else begin : g_pre
    logic [FADE_PRESCALE-1:0] pre_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else if (state_q == XFADE) pre_q <= pre_q + 1'b1;
      else pre_q <= '0;
    end
    assign tick = &pre_q;
  end

  assign mask8 = 8'(src_enable);
  assign cand  = SEL_W'(next_enabled(3'(cur_q), mask8));
  assign trig  = (auto_mode && (&dwell_q)) || btn_rise;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    dwell_d = '0;
    ramp_d  = ramp_q;
    acc_d   = acc_q;
    leds_d  = leds_q;
    unique case (state_q)
      NONE: begin
        leds_d = '0;
        if (|src_enable) begin
          cur_d   = SEL_W'(next_enabled(3'd7, mask8));
          state_d = SHOW;
        end
      end
      SHOW: begin
        leds_d = src[cur_q];
        if (!src_enable[cur_q]) begin
          if (src_enable[cand]) begin
            nxt_d   = cand;
            ramp_d  = '0;
            acc_d   = '0;
            state_d = XFADE;
          end else begin
            leds_d  = '0;
            state_d = NONE;
          end
        end else if (trig) begin
          if (cand != cur_q) begin
            nxt_d   = cand;
            ramp_d  = '0;
            acc_d   = '0;
            state_d = XFADE;
          end
        end else if (auto_mode) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      XFADE: begin
        leds_d = acc_q[FADE_BITS] ? src[nxt_q] : src[cur_q];
        acc_d  = {1'b0, acc_q[FADE_BITS-1:0]} + {1'b0, ramp_q};
        if (!src_enable[nxt_q]) begin
          ramp_d = '0;
          acc_d  = '0;
          if (src_enable[cur_q]) begin
            state_d = SHOW;
          end else begin
            leds_d  = '0;
            state_d = NONE;
          end
        end else if (tick) begin
          if (&ramp_q) begin
            cur_d   = nxt_q;
            ramp_d  = '0;
            acc_d   = '0;
            state_d = SHOW;
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end
      end
      default: begin
        leds_d  = '0;
        state_d = NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NONE;
      cur_q   <= '0;
      nxt_q   <= '0;
      dwell_q <= '0;
      ramp_q  <= '0;
      acc_q   <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      dwell_q <= dwell_d;
      ramp_q  <= ramp_d;
      acc_q   <= acc_d;
      leds_q  <= leds_d;
    end
  end

  assign leds       = leds_q;
  assign fading     = (state_q == XFADE);
  assign active_src = (state_q == XFADE) ? nxt_q : cur_q;

endmodule

// File: tb/tb_led_source_scheduler.sv
// Directed bench for led_source_scheduler with short dwell, fade and
// debounce settings and one-hot constant sources.
module tb_led_source_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_data = 32'h0804_0201;
  logic [3:0]  src_enable = 4'h0;
  logic        auto_mode = 1'b0;
  logic        advance_btn = 1'b0;
  logic [7:0]  leds;
  logic [1:0]  active_src;
  logic        fading;

  led_source_scheduler #(
    .NUM_SRC       (4),
    .DWELL_W       (4),
    .FADE_BITS     (4),
    .FADE_PRESCALE (0),
    .DEBOUNCE_W    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data    (src_data),
    .src_enable  (src_enable),
    .auto_mode   (auto_mode),
    .advance_btn (advance_btn),
    .leds        (leds),
    .active_src  (active_src),
    .fading      (fading)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  int   fades = 0;
  logic fad_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (fading && !fad_q) fades++;
    fad_q = fading;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_fading", 32'(fading), 32'h0);
    check("rst_active", 32'(active_src), 32'h0);
    rst_n = 1'b1;
    fades = 0;
    fad_q = 1'b0;
  endtask

  int n;
  int bad;
  int hi1;
  int hi2;
  int n_end;
  logic [1:0] ends [2];
  logic prev;
  logic [7:0] smp [16];

  initial begin
    // 1: reset, all enabled, manual mode
    src_enable = 4'hf;
    auto_mode  = 1'b0;
    do_reset();
    step();
    step();
    check("t1_leds", 32'(leds), 32'h01);
    check("t1_active", 32'(active_src), 32'h0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (leds !== 8'h01 || fading !== 1'b0) bad++;
    end
    check("t1_hold", 32'(bad), 32'h0);

    // 2: dwell advance and crossfade shape
    auto_mode = 1'b1;
    n = 0;
    while (!fading && n < 40) begin
      step();
      n++;
    end
    check("t2_dwell", 32'(n), 32'd16);
    n = 0;
    bad = 0;
    while (fading && n < 40) begin
      if (n < 16) smp[n] = leds;
      if (leds !== 8'h01 && leds !== 8'h02) bad++;
      step();
      n++;
    end
    check("t2_fadelen", 32'(n), 32'd16);
    check("t2_legal", 32'(bad), 32'h0);
    check("t2_leds", 32'(leds), 32'h02);
    check("t2_active", 32'(active_src), 32'h1);
    hi1 = 0;
    hi2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (smp[i] == 8'h02) begin
        if (i < 8) hi1++;
        else hi2++;
      end
    end
    check("t2_rising", 32'(hi2 > hi1), 32'h1);
    check("t2_duty", 32'(hi1 + hi2), 32'd5);

    // 3: wrap-around over sources 0 and 3
    src_enable = 4'b1001;
    auto_mode  = 1'b1;
    do_reset();
    step();
    n_end = 0;
    bad = 0;
    ends[0] = 2'd0;
    ends[1] = 2'd0;
    for (int i = 0; i < 200 && n_end < 2; i++) begin
      prev = fading;
      step();
      if (leds !== 8'h01 && leds !== 8'h08) bad++;
      if (prev && !fading) begin
        ends[n_end] = active_src;
        n_end++;
      end
    end
    check("t3_fades", 32'(n_end), 32'd2);
    check("t3_first", 32'(ends[0]), 32'd3);
    check("t3_second", 32'(ends[1]), 32'd0);
    check("t3_legal", 32'(bad), 32'h0);

    // 4: bouncing button, held press, press during fade
    src_enable = 4'hf;
    auto_mode  = 1'b0;
    do_reset();
    repeat (10) step();
    advance_btn = 1'b1;
    step();
    advance_btn = 1'b0;
    step();
    advance_btn = 1'b1;
    n = 0;
    while (!fading && n < 30) begin
      step();
      n++;
    end
    check("t4_latency", 32'(n), 32'd7);
    repeat (20) step();
    advance_btn = 1'b0;
    repeat (30) step();
    check("t4_one_adv", 32'(fades), 32'd1);
    check("t4_active1", 32'(active_src), 32'd1);
    advance_btn = 1'b1;
    n = 0;
    while (!fading && n < 30) begin
      step();
      n++;
    end
    check("t4_latency2", 32'(n), 32'd7);
    advance_btn = 1'b0;
    repeat (6) step();
    advance_btn = 1'b1;
    repeat (40) step();
    check("t4_drop", 32'(fades), 32'd2);
    check("t4_active2", 32'(active_src), 32'd2);
    advance_btn = 1'b0;

    // 5: single source never fades, then none enabled
    src_enable = 4'b0001;
    auto_mode  = 1'b1;
    do_reset();
    repeat (60) step();
    check("t5_nofade", 32'(fades), 32'd0);
    check("t5_leds", 32'(leds), 32'h01);
    src_enable = 4'b0000;
    step();
    check("t5_off", 32'(leds), 32'h0);
    check("t5_offfade", 32'(fading), 32'h0);

    // 6: asynchronous reset in the middle of a fade
    src_enable = 4'hf;
    auto_mode  = 1'b1;
    do_reset();
    n = 0;
    while (!fading && n < 40) begin
      step();
      n++;
    end
    check("t6_fading", 32'(fading), 32'h1);
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    check("t6_leds", 32'(leds), 32'h0);
    check("t6_fade", 32'(fading), 32'h0);
    check("t6_active", 32'(active_src), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("t6_rec_leds", 32'(leds), 32'h01);
    check("t6_rec_act", 32'(active_src), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
